dac_sample_scheduler: RTL and testbench
=======================================

Name: dac_sample_scheduler

Overview:
- Sits between the packet receiver and the 48 kHz I2S DAC driver.
- Buffers stereo 48-bit samples (left in [47:24], right in [23:0]) in a small FIFO and sequences playback through MUTE/PREFILL/PLAY states.
- Answers the driver's one-cycle read-request pulse, drives its wait/hold input, and outputs silence on underrun.
- Reports fill level and underrun statistics to the control block.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 4..256).
- PREFILL, 8, entries required before leaving PREFILL (1..DEPTH).
- AW, $clog2(DEPTH), FIFO address width (derived, not overridable).

Ports:
- i_clk36  in  1  36.864 MHz system/audio clock.
- i_rst36_n  in  1  asynchronous active-low reset.
- i_en  in  1  playback enable; low forces MUTE and flushes FIFO.
- i_pause  in  1  hold current DAC sample while in PLAY.
- i_wr_valid  in  1  upstream sample valid.
- i_wr_data  in  48  upstream sample {L[23:0], R[23:0]}.
- o_wr_ready  out  1  FIFO not full and i_en high.
- i_dac_rdreq  in  1  one-cycle pulse from DAC driver (>=768 cycles apart).
- o_dac_wait  out  1  to driver wait input.
- o_dac_lraudio  out  48  sample presented to driver.
- o_level  out  AW+1  current FIFO occupancy.
- o_playing  out  1  state == PLAY.
- o_underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset (async assert, sync release) sets: state MUTE, FIFO empty, o_level 0, o_dac_lraudio 0, o_dac_wait 0, o_wr_ready 0, o_playing 0, o_underrun_cnt 0.
- Write: push when i_wr_valid && o_wr_ready. o_wr_ready = i_en && (level < DEPTH), registered from next-state level. There is no overflow path.
- Capture timing: the driver captures o_dac_lraudio on the same edge it raises i_dac_rdreq. o_dac_lraudio is therefore a register that must be stable before the pulse. The pop occurs in the cycle i_dac_rdreq is high, and the new head is registered onto o_dac_lraudio on the next edge (1-cycle latency).
- State MUTE:
  - o_dac_lraudio = 0, o_dac_wait = 0 (driver plays silence).
  - FIFO pointers held cleared while i_en low.
  - i_en high -> PREFILL.
- State PREFILL:
  - Writes accepted. o_dac_lraudio = 0. i_dac_rdreq does not pop.
  - level >= PREFILL -> PLAY, with the head loaded onto o_dac_lraudio on the same transition edge.
- State PLAY:
  - o_dac_lraudio = FIFO head; pop on i_dac_rdreq.
  - If the pop empties the FIFO and no simultaneous push occurs, the next presented value is the one available after the push/pop resolves, else 0.
  - If i_dac_rdreq arrives while level == 0: underrun. No pop, o_dac_lraudio <= 0, o_underrun_cnt += 1 (saturates at 0xFFFF), -> PREFILL.
  - i_pause high: o_dac_wait = 1, i_dac_rdreq ignored (no pop, no underrun). Writes continue.
  - Pause release returns o_dac_wait to 0 on the next edge.
- Simultaneous push and pop: level unchanged; head advances to the correct entry (a push into an empty FIFO with a pop in the same cycle pops nothing).
- i_en low in any state -> MUTE next edge:
  - FIFO flushed, o_dac_lraudio <= 0, o_dac_wait <= 0.
  - Any write in that cycle is dropped.
  - o_underrun_cnt retained.
- Pointers are AW bits and wrap modulo DEPTH; level uses AW+1 bits, so full == DEPTH.
- o_dac_wait is only ever high in PLAY with i_pause.
- Storage: inferred RAM or register array; no combinational path from i_dac_rdreq to o_dac_lraudio.

Test Plan:
- Reset mid-PLAY with 5 entries: assert i_rst36_n low -> all outputs 0 immediately, state MUTE, level 0 after release.
- i_en=1, write 8 samples 0x000001_FFFFFF.. -> PLAY entered when level hits 8; o_dac_lraudio = first sample before the first rdreq; each rdreq advances by one sample; level decrements.
- Fill to DEPTH=16 -> o_wr_ready 0, and the 17th i_wr_valid is not stored. One rdreq -> o_wr_ready 1 the next cycle.
- PLAY with level 1: rdreq pops the last entry, next rdreq with no writes -> o_underrun_cnt=1, o_dac_lraudio=0, state PREFILL, o_playing 0.
- PLAY, i_pause=1 for 3 rdreq pulses -> o_dac_wait=1, level and o_dac_lraudio unchanged, no underrun count. Release -> normal pops resume.
- Push and rdreq in the same cycle at level 4 -> level stays 4 and sample order is preserved.
- i_en dropped at level 10 -> MUTE, level 0, silence output, counter unchanged.

Source files
------------

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler
// Buffers stereo samples from the packet receiver in a small FIFO and plays
// them out to the I2S DAC driver through MUTE -> PREFILL -> PLAY sequencing.
// The sample shown to the driver is always a register, because the driver
// captures it on the same edge it raises its read request.
module dac_sample_scheduler #(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic                    i_clk36,
  input  logic                    i_rst36_n,
  input  logic                    i_en,
  input  logic                    i_pause,
  input  logic                    i_wr_valid,
  input  logic [47:0]             i_wr_data,
  output logic                    o_wr_ready,
  input  logic                    i_dac_rdreq,
  output logic                    o_dac_wait,
  output logic [47:0]             o_dac_lraudio,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_playing,
  output logic [15:0]             o_underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_PREFILL = (AW+1)'(PREFILL);

  typedef enum logic [1:0] {
    ST_MUTE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

  logic [1:0]    r_rstSync;
  logic          w_rstN;

  state_t        r_state;
  state_t        w_stateNext;

  logic [47:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_level;
  logic          r_wrReady;
  logic          r_wait;
  logic [47:0]   r_lraudio;
  logic [15:0]   r_underrunCnt;

  logic          w_push;
  logic          w_pop;
  logic          w_underrun;
  logic [AW:0]   w_levelAfterPop;
  logic [AW:0]   w_levelNext;
  logic [AW-1:0] w_wrPtrNext;
  logic [AW-1:0] w_rdPtrNext;
  logic [47:0]   w_headNext;
  logic [47:0]   w_lraudioNext;
  logic          w_waitNext;
  logic          w_wrReadyNext;

  // Reset asserts immediately but is released only on a clock edge
  always_ff @(posedge i_clk36 or negedge i_rst36_n) begin
    if (!i_rst36_n) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN = r_rstSync[1];

  // Playback state register
  always_ff @(posedge i_clk36 or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state <= ST_MUTE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state plus the push/pop/underrun decisions that drive it
  always_comb begin
    w_stateNext = r_state;
    w_pop       = 1'b0;
    w_underrun  = 1'b0;
    w_push      = i_en && i_wr_valid && r_wrReady;

    // A read request only matters while playing and not paused; with
    // nothing buffered it is an underrun instead of a pop
    if (i_en && (r_state == ST_PLAY) && i_dac_rdreq && !i_pause) begin
      if (r_level == '0) begin
        w_underrun = 1'b1;
      end else begin
        w_pop = 1'b1;
      end
    end

    case (r_state)
      ST_MUTE: begin
        if (i_en) begin
          w_stateNext = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if (r_level >= LVL_PREFILL) begin
          w_stateNext = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (w_underrun) begin
          w_stateNext = ST_PREFILL;
        end
      end
      default: begin
        w_stateNext = ST_MUTE;
      end
    endcase

    if (!i_en) begin
      w_stateNext = ST_MUTE;
    end
  end

  // Pointer/level arithmetic and the head value seen after this cycle
  always_comb begin
    w_levelAfterPop = r_level - (AW+1)'(w_pop);
    w_levelNext     = w_levelAfterPop + (AW+1)'(w_push);
    w_wrPtrNext     = r_wrPtr + AW'(w_push);
    w_rdPtrNext     = r_rdPtr + AW'(w_pop);

    // Disabling playback flushes the FIFO in the same edge
    if (!i_en) begin
      w_levelNext = '0;
      w_wrPtrNext = '0;
      w_rdPtrNext = '0;
    end

    // If the FIFO is empty once the pop resolves, a push landing this
    // cycle becomes the head directly since it is not in the array yet
    w_headNext = '0;
    if (w_levelNext != '0) begin
      if (w_levelAfterPop == '0) begin
        w_headNext = i_wr_data;
      end else begin
        w_headNext = r_mem[w_rdPtrNext];
      end
    end

    w_lraudioNext = (w_stateNext == ST_PLAY) ? w_headNext : 48'd0;
    w_waitNext    = (w_stateNext == ST_PLAY) && i_pause;
    w_wrReadyNext = i_en && (w_levelNext < LVL_FULL);
  end

  // Sample storage, left unreset so it can map onto RAM
  always_ff @(posedge i_clk36) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wr_data;
    end
  end

  // FIFO pointers, occupancy and registered driver-facing outputs
  always_ff @(posedge i_clk36 or negedge w_rstN) begin
    if (!w_rstN) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_wrReady <= 1'b0;
      r_wait    <= 1'b0;
      r_lraudio <= '0;
    end else begin
      r_wrPtr   <= w_wrPtrNext;
      r_rdPtr   <= w_rdPtrNext;
      r_level   <= w_levelNext;
      r_wrReady <= w_wrReadyNext;
      r_wait    <= w_waitNext;
      r_lraudio <= w_lraudioNext;
    end
  end

  // Saturating underrun statistic, kept across disable/enable cycles
  always_ff @(posedge i_clk36 or negedge w_rstN) begin
    if (!w_rstN) begin
      r_underrunCnt <= '0;
    end else if (w_underrun && (r_underrunCnt != 16'hFFFF)) begin
      r_underrunCnt <= r_underrunCnt + 16'd1;
    end
  end

  assign o_wr_ready     = r_wrReady;
  assign o_dac_wait     = r_wait;
  assign o_dac_lraudio  = r_lraudio;
  assign o_level        = r_level;
  assign o_playing      = (r_state == ST_PLAY);
  assign o_underrun_cnt = r_underrunCnt;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler
// Directed bench for dac_sample_scheduler with DEPTH=16, PREFILL=8.
`timescale 1ns/1ps
module tb_dac_sample_scheduler;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        en = 1'b0;
  logic        pause = 1'b0;
  logic        wrValid = 1'b0;
  logic [47:0] wrData = '0;
  logic        rdreq = 1'b0;

  logic        wrReady;
  logic        dacWait;
  logic [47:0] lraudio;
  logic [4:0]  level;
  logic        playing;
  logic [15:0] underrunCnt;

  int compared = 0;
  int mismatched = 0;

  dac_sample_scheduler #(.DEPTH(16), .PREFILL(8)) dut (
    .i_clk36        (clk),
    .i_rst36_n      (rstN),
    .i_en           (en),
    .i_pause        (pause),
    .i_wr_valid     (wrValid),
    .i_wr_data      (wrData),
    .o_wr_ready     (wrReady),
    .i_dac_rdreq    (rdreq),
    .o_dac_wait     (dacWait),
    .o_dac_lraudio  (lraudio),
    .o_level        (level),
    .o_playing      (playing),
    .o_underrun_cnt (underrunCnt)
  );

  // Free-running ~36 MHz clock
  always #14 clk = ~clk;

  // Sample k is {k, FFFFFF-(k-1)}, so sample 1 is 000001_FFFFFF
  function automatic logic [47:0] sampleOf(input int k);
    logic [23:0] l;
    logic [23:0] r;
    l = 24'(k);
    r = 24'hFFFFFF - 24'(k - 1);
    return {l, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of stimulus, then look 1 ns after the edge
  task automatic applyStimulus(input logic wv, input logic [47:0] wd, input logic rq);
    wrValid = wv;
    wrData  = wd;
    rdreq   = rq;
    @(posedge clk);
    #1;
    wrValid = 1'b0;
    rdreq   = 1'b0;
  endtask

  task automatic tick();
    applyStimulus(1'b0, 48'd0, 1'b0);
  endtask

  task automatic writeSample(input int k);
    applyStimulus(1'b1, sampleOf(k), 1'b0);
  endtask

  task automatic popOnce();
    applyStimulus(1'b0, 48'd0, 1'b1);
  endtask

  initial begin
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_audio", 64'(lraudio), 64'd0);
    checkOutput("rst_wait", 64'(dacWait), 64'd0);
    checkOutput("rst_ready", 64'(wrReady), 64'd0);
    checkOutput("rst_playing", 64'(playing), 64'd0);
    checkOutput("rst_cnt", 64'(underrunCnt), 64'd0);
    rstN = 1'b1;
    repeat (3) tick();
    checkOutput("mute_ready", 64'(wrReady), 64'd0);
    checkOutput("mute_playing", 64'(playing), 64'd0);

    // Enable: MUTE -> PREFILL
    en = 1'b1;
    tick();
    checkOutput("pre_ready", 64'(wrReady), 64'd1);
    checkOutput("pre_playing", 64'(playing), 64'd0);

    // Prefill; a read request here must not pop
    for (int k = 1; k <= 3; k++) writeSample(k);
    popOnce();
    checkOutput("pre_rdreq_level", 64'(level), 64'd3);
    checkOutput("pre_rdreq_cnt", 64'(underrunCnt), 64'd0);
    for (int k = 4; k <= 8; k++) writeSample(k);
    checkOutput("pre8_level", 64'(level), 64'd8);
    checkOutput("pre8_playing", 64'(playing), 64'd0);
    checkOutput("pre8_audio", 64'(lraudio), 64'd0);
    tick();
    checkOutput("play_enter", 64'(playing), 64'd1);
    checkOutput("play_head", 64'(lraudio), 64'(sampleOf(1)));

    // Two pops advance the head
    popOnce();
    checkOutput("pop1_audio", 64'(lraudio), 64'(sampleOf(2)));
    checkOutput("pop1_level", 64'(level), 64'd7);
    popOnce();
    checkOutput("pop2_audio", 64'(lraudio), 64'(sampleOf(3)));
    checkOutput("pop2_level", 64'(level), 64'd6);

    // Fill to 16; the extra write is refused
    for (int k = 9; k <= 18; k++) writeSample(k);
    checkOutput("full_level", 64'(level), 64'd16);
    checkOutput("full_ready", 64'(wrReady), 64'd0);
    applyStimulus(1'b1, sampleOf(99), 1'b0);
    checkOutput("full_drop_level", 64'(level), 64'd16);
    checkOutput("full_head", 64'(lraudio), 64'(sampleOf(3)));
    popOnce();
    checkOutput("unfull_ready", 64'(wrReady), 64'd1);
    checkOutput("unfull_level", 64'(level), 64'd15);
    checkOutput("unfull_audio", 64'(lraudio), 64'(sampleOf(4)));

    // Drain to level 4 (head sample 15), checking order including wrap
    for (int j = 1; j <= 11; j++) begin
      popOnce();
      checkOutput("drain_audio", 64'(lraudio), 64'(sampleOf(4 + j)));
      checkOutput("drain_level", 64'(level), 64'(15 - j));
    end

    // Push and pop together at level 4
    applyStimulus(1'b1, sampleOf(19), 1'b1);
    checkOutput("pp_level", 64'(level), 64'd4);
    checkOutput("pp_audio", 64'(lraudio), 64'(sampleOf(16)));
    for (int k = 17; k <= 19; k++) begin
      popOnce();
      checkOutput("pp_order", 64'(lraudio), 64'(sampleOf(k)));
    end
    checkOutput("lvl1_level", 64'(level), 64'd1);

    // Push and pop at level 1: pushed sample becomes the head directly
    applyStimulus(1'b1, sampleOf(50), 1'b1);
    checkOutput("bypass_level", 64'(level), 64'd1);
    checkOutput("bypass_audio", 64'(lraudio), 64'(sampleOf(50)));

    // Pop last entry, then underrun
    popOnce();
    checkOutput("empty_level", 64'(level), 64'd0);
    checkOutput("empty_audio", 64'(lraudio), 64'd0);
    checkOutput("empty_playing", 64'(playing), 64'd1);
    popOnce();
    checkOutput("ur_cnt", 64'(underrunCnt), 64'd1);
    checkOutput("ur_audio", 64'(lraudio), 64'd0);
    checkOutput("ur_playing", 64'(playing), 64'd0);
    checkOutput("ur_level", 64'(level), 64'd0);

    // Back to PLAY, then pause
    for (int k = 20; k <= 27; k++) writeSample(k);
    tick();
    checkOutput("replay_audio", 64'(lraudio), 64'(sampleOf(20)));
    pause = 1'b1;
    tick();
    checkOutput("pause_wait", 64'(dacWait), 64'd1);
    for (int j = 0; j < 3; j++) begin
      popOnce();
      checkOutput("pause_level", 64'(level), 64'd8);
      checkOutput("pause_audio", 64'(lraudio), 64'(sampleOf(20)));
      checkOutput("pause_cnt", 64'(underrunCnt), 64'd1);
      tick();
    end
    writeSample(28);
    checkOutput("pause_write", 64'(level), 64'd9);
    pause = 1'b0;
    tick();
    checkOutput("unpause_wait", 64'(dacWait), 64'd0);
    popOnce();
    checkOutput("resume_audio", 64'(lraudio), 64'(sampleOf(21)));
    checkOutput("resume_level", 64'(level), 64'd8);

    // Disable at level 10 with a write in the same cycle
    writeSample(29);
    writeSample(30);
    checkOutput("pre_dis_level", 64'(level), 64'd10);
    en = 1'b0;
    applyStimulus(1'b1, sampleOf(99), 1'b0);
    checkOutput("dis_level", 64'(level), 64'd0);
    checkOutput("dis_audio", 64'(lraudio), 64'd0);
    checkOutput("dis_playing", 64'(playing), 64'd0);
    checkOutput("dis_ready", 64'(wrReady), 64'd0);
    checkOutput("dis_cnt", 64'(underrunCnt), 64'd1);

    // Re-enable, reach PLAY with 5 entries, then reset mid-cycle
    en = 1'b1;
    tick();
    for (int k = 31; k <= 38; k++) writeSample(k);
    tick();
    checkOutput("re_audio", 64'(lraudio), 64'(sampleOf(31)));
    repeat (3) popOnce();
    checkOutput("re_level", 64'(level), 64'd5);
    checkOutput("re_head", 64'(lraudio), 64'(sampleOf(34)));
    #5;
    rstN = 1'b0;
    #1;
    checkOutput("arst_level", 64'(level), 64'd0);
    checkOutput("arst_audio", 64'(lraudio), 64'd0);
    checkOutput("arst_playing", 64'(playing), 64'd0);
    checkOutput("arst_ready", 64'(wrReady), 64'd0);
    checkOutput("arst_cnt", 64'(underrunCnt), 64'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    repeat (4) tick();
    checkOutput("post_rst_level", 64'(level), 64'd0);
    checkOutput("post_rst_playing", 64'(playing), 64'd0);
    checkOutput("post_rst_audio", 64'(lraudio), 64'd0);
    checkOutput("post_rst_ready", 64'(wrReady), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
